tcp_rx_parser: RTL and testbench
================================

Name: tcp_rx_parser

Overview:
- Receive-direction counterpart of the TX header builder.
- Consumes an incoming Ethernet/IPv4/TCP frame as a 32-bit big-endian word stream and extracts the fields the TOE connection logic needs: MAC src, IP src/dst, ports, seq, ack, flags, window and payload length.
- Validates the headers and presents one parsed-header record per good frame on a valid/ready interface.
- Discards payload and counts dropped frames.

Parameters:
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_data  in  32  frame word; byte 0 in [31:24]
- in_valid  in  1  in_data valid
- in_sop  in  1  first word of frame
- in_eop  in  1  last word of frame
- in_ready  out  1  parser accepts the word this cycle
- local_mac  in  48  station MAC for destination filtering
- hdr_valid  out  1  parsed record available
- hdr_ready  in  1  consumer takes the record
- hdr_mac_src  out  48
- hdr_ip_src, hdr_ip_dst  out  32 each
- hdr_src_port, hdr_dst_port  out  16 each
- hdr_seq, hdr_ack  out  32 each
- hdr_flags  out  8  TCP flag byte
- hdr_window  out  16
- hdr_payload_len  out  16  TCP payload bytes
- drop_count  out  CNT_W  saturating count of rejected frames

Behaviour:
- Clock and reset: single clock domain. Async reset clears the FSM, word index, all hdr_* outputs, hdr_valid and drop_count to 0. A reset mid-frame discards the frame without counting it.
- Beat acceptance: a word is accepted when in_valid && in_ready.
- Word map (index w from SOP = 0):
  - w0 = dst[47:16]
  - w1 = dst[15:0], src[47:32]
  - w2 = src[31:0]
  - w3 = ethertype, ver/IHL, TOS
  - w4 = ip_len, ip_id
  - w5 = frag, TTL, proto
  - w6 = ip_csum, ipsrc[31:16]
  - w7 = ipsrc[15:0], ipdst[31:16]
  - w8 = ipdst[15:0], sport
  - w9 = dport, seq[31:16]
  - w10 = seq[15:0], ack[31:16]
  - w11 = ack[15:0], offset/rsvd byte, flags byte
  - w12 = window, tcp_csum
  - w13 = urgent ptr, 2 payload bytes
- FSM states:
  - IDLE: in_ready = 1. Words without in_sop are ignored. An SOP word is captured as w0 and the FSM moves to HDR (w = 1).
  - HDR: in_ready = 1, except on w13 while hdr_valid && !hdr_ready, where it is 0 (stall). Each accepted word is latched into a shadow register and w increments.
  - On acceptance of w13:
    - Run the checks.
    - On pass, shadow fields load the hdr_* outputs and hdr_valid = 1 in the following cycle (latency 1 cycle after the w13 beat).
    - Next state is IDLE if in_eop on w13, else SKIP.
  - SKIP: in_ready = 1. Payload words are discarded; in_eop returns the FSM to IDLE.
- Checks (all must hold):
  - dst MAC == local_mac or 48'hFFFF_FFFF_FFFF
  - ethertype == 16'h0800
  - version == 4, IHL == 5
  - proto == 8'd6
  - TCP data offset >= 5
  - ip_len >= 20 + 4*offset
- Payload length: hdr_payload_len = ip_len − 20 − 4*offset, computed in 16 bits; the last check guarantees no underflow.
- Drops: any check failure, or in_eop before w13 (runt), increments drop_count by 1. drop_count saturates at all-ones. A failing frame with remaining words goes to SKIP.
- SOP while in HDR: the current frame is counted as a runt drop and the new word is taken as w0. SOP while in SKIP: treated as a new frame w0 (the missing EOP is tolerated, not counted).
- Output handshake: hdr_valid stays high with stable fields until hdr_ready. hdr_valid && hdr_ready clears hdr_valid next cycle, unless a new record loads that same cycle, in which case hdr_valid stays 1 with the new fields.
- Single-entry output register; no FIFO.

Decomposition:
- Package tcp_rx_pkg:
  - ETHERTYPE_IPV4 = 16'h0800, IP_PROTO_TCP = 8'd6, HDR_LAST_WORD = 4'd13, BCAST_MAC
  - rx_state_t enum {IDLE, HDR, SKIP}
  - tcp_rx_hdr_t packed struct holding the output fields
- Sub-module: tcp_rx_hdr_check, purely combinational. Takes the shadow fields and local_mac; outputs pass and payload_len.

Test Plan:
- Good frame: dst = local_mac, ip_len = 16'd60, offset = 5, seq = 32'h1000_0001, ack = 32'h2000_0002, flags = 8'h18, 16 words total -> hdr_valid one cycle after w13 beat; hdr_payload_len = 20; seq/ack/ports exact; drop_count = 0; FSM back to IDLE after EOP.
- Rejects: ethertype 16'h86DD, then proto 17, then dst MAC mismatch -> no hdr_valid; drop_count = 3.
- Runt: EOP on w7 -> drop_count += 1. Next good frame parses correctly.
- Backpressure: hdr_ready = 0 with a record pending, second good frame -> in_ready = 0 at w13 until hdr_ready pulses; second record intact; first record stable while held.
- SOP at w5 of a frame -> first counted as runt, second parsed. drop_count forced to 16'hFFFF plus one more bad frame -> stays 16'hFFFF.
- reset_n low at w9, then release -> all outputs 0, drop_count 0; next frame parses.

Source files
------------

// File: rtl/tcp_rx_pkg.sv
// Shared definitions for the TCP receive-side header parser.
// Holds protocol constants, the parser state encoding and the packed record
// that carries one parsed header from the parser to the connection logic.
package tcp_rx_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_TCP   = 8'd6;
  localparam logic [3:0]  HDR_LAST_WORD  = 4'd13;
  localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    SKIP
  } rx_state_t;

  typedef struct packed {
    logic [47:0] mac_src;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [7:0]  flags;
    logic [15:0] window;
    logic [15:0] payload_len;
  } tcp_rx_hdr_t;

endpackage

// File: rtl/tcp_rx_parser_hdr_check.sv
// Combinational header validation for one captured frame.
// Ports:
//   dst_mac, local_mac : destination MAC of the frame and our station MAC
//   ethertype, ver_ihl  : Ethernet type and IPv4 version/IHL byte
//   proto               : IPv4 protocol byte
//   data_off            : TCP data offset in 32-bit words
//   ip_len              : IPv4 total length in bytes
//   pass                : every check holds
//   payload_len         : TCP payload bytes (meaningful only when pass = 1)
module tcp_rx_hdr_check
  import tcp_rx_pkg::*;
(
  input  logic [47:0] dst_mac,
  input  logic [47:0] local_mac,
  input  logic [15:0] ethertype,
  input  logic [7:0]  ver_ihl,
  input  logic [7:0]  proto,
  input  logic [3:0]  data_off,
  input  logic [15:0] ip_len,
  output logic        pass,
  output logic [15:0] payload_len
);

  logic [15:0] hdr_bytes;
  logic        mac_ok;

  // IP header is fixed at 20 bytes (IHL must be 5); TCP header is 4*offset.
  // The length check guarantees the subtraction below cannot wrap when pass.
  always_comb begin
    hdr_bytes   = 16'd20 + {10'd0, data_off, 2'b00};
    mac_ok      = (dst_mac == local_mac) || (dst_mac == BCAST_MAC);
    pass        = mac_ok
                  && (ethertype == ETHERTYPE_IPV4)
                  && (ver_ihl == 8'h45)
                  && (proto == IP_PROTO_TCP)
                  && (data_off >= 4'd5)
                  && (ip_len >= hdr_bytes);
    payload_len = ip_len - hdr_bytes;
  end

endmodule

// File: rtl/tcp_rx_parser.sv
// Receive-side Ethernet/IPv4/TCP header parser.
// Consumes a 32-bit big-endian word stream, captures the header fields of
// words 0..13, validates them and presents one record per good frame on a
// single-entry valid/ready output. Payload is discarded; rejected and runt
// frames bump a saturating drop counter.
// Ports:
//   clk, reset_n                      : clock, async active-low reset
//   in_data/in_valid/in_sop/in_eop    : input word stream
//   in_ready                          : word accepted this cycle when valid
//   local_mac                         : station MAC for destination filter
//   hdr_valid/hdr_ready               : output record handshake
//   hdr_*                             : parsed header record fields
//   drop_count                        : saturating rejected-frame count
module tcp_rx_parser
  import tcp_rx_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic             in_ready,
  input  logic [47:0]      local_mac,
  output logic             hdr_valid,
  input  logic             hdr_ready,
  output logic [47:0]      hdr_mac_src,
  output logic [31:0]      hdr_ip_src,
  output logic [31:0]      hdr_ip_dst,
  output logic [15:0]      hdr_src_port,
  output logic [15:0]      hdr_dst_port,
  output logic [31:0]      hdr_seq,
  output logic [31:0]      hdr_ack,
  output logic [7:0]       hdr_flags,
  output logic [15:0]      hdr_window,
  output logic [15:0]      hdr_payload_len,
  output logic [CNT_W-1:0] drop_count
);

  rx_state_t   state, state_nxt;
  logic [3:0]  widx, widx_nxt;
  logic        accept;
  logic        load;
  logic        drop_inc;

  logic [47:0] sh_dst, sh_src;
  logic [15:0] sh_ethertype, sh_ip_len;
  logic [7:0]  sh_ver_ihl, sh_proto, sh_flags;
  logic [31:0] sh_ip_src, sh_ip_dst, sh_seq, sh_ack;
  logic [15:0] sh_sport, sh_dport, sh_window;
  logic [3:0]  sh_data_off;

  logic        chk_pass;
  logic [15:0] chk_payload_len;

  tcp_rx_hdr_t hdr_q;

  tcp_rx_hdr_check u_check (
    .dst_mac     (sh_dst),
    .local_mac   (local_mac),
    .ethertype   (sh_ethertype),
    .ver_ihl     (sh_ver_ihl),
    .proto       (sh_proto),
    .data_off    (sh_data_off),
    .ip_len      (sh_ip_len),
    .pass        (chk_pass),
    .payload_len (chk_payload_len)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      widx  <= '0;
    end else begin
      state <= state_nxt;
      widx  <= widx_nxt;
    end
  end

  // The only stall is on the final header word while the previous record is
  // still unclaimed, so the output register is never overwritten. An SOP
  // restarts capture from any state; in HDR that abandons a runt frame.
  always_comb begin
    state_nxt = state;
    widx_nxt  = widx;
    drop_inc  = 1'b0;
    load      = 1'b0;
    in_ready  = !((state == HDR) && (widx == HDR_LAST_WORD)
                  && hdr_valid && !hdr_ready);
    accept    = in_valid && in_ready;
    if (accept) begin
      if (in_sop) begin
        if (state == HDR) drop_inc = 1'b1;
        if (in_eop) begin
          drop_inc  = 1'b1;
          state_nxt = IDLE;
          widx_nxt  = '0;
        end else begin
          state_nxt = HDR;
          widx_nxt  = 4'd1;
        end
      end else begin
        case (state)
          HDR: begin
            if (widx == HDR_LAST_WORD) begin
              load      = chk_pass;
              drop_inc  = !chk_pass;
              state_nxt = in_eop ? IDLE : SKIP;
              widx_nxt  = '0;
            end else if (in_eop) begin
              drop_inc  = 1'b1;
              state_nxt = IDLE;
              widx_nxt  = '0;
            end else begin
              widx_nxt = widx + 4'd1;
            end
          end
          SKIP: begin
            if (in_eop) state_nxt = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Shadow capture: each header word lands in its fields by index. Every
  // field the checks need is complete by word 12, so word 13 only triggers
  // the decision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_dst       <= '0;
      sh_src       <= '0;
      sh_ethertype <= '0;
      sh_ver_ihl   <= '0;
      sh_ip_len    <= '0;
      sh_proto     <= '0;
      sh_ip_src    <= '0;
      sh_ip_dst    <= '0;
      sh_sport     <= '0;
      sh_dport     <= '0;
      sh_seq       <= '0;
      sh_ack       <= '0;
      sh_data_off  <= '0;
      sh_flags     <= '0;
      sh_window    <= '0;
    end else if (accept) begin
      if (in_sop) begin
        sh_dst[47:16] <= in_data;
      end else if (state == HDR) begin
        case (widx)
          4'd1: begin
            sh_dst[15:0]  <= in_data[31:16];
            sh_src[47:32] <= in_data[15:0];
          end
          4'd2: sh_src[31:0] <= in_data;
          4'd3: begin
            sh_ethertype <= in_data[31:16];
            sh_ver_ihl   <= in_data[15:8];
          end
          4'd4: sh_ip_len <= in_data[31:16];
          4'd5: sh_proto  <= in_data[7:0];
          4'd6: sh_ip_src[31:16] <= in_data[15:0];
          4'd7: begin
            sh_ip_src[15:0]  <= in_data[31:16];
            sh_ip_dst[31:16] <= in_data[15:0];
          end
          4'd8: begin
            sh_ip_dst[15:0] <= in_data[31:16];
            sh_sport        <= in_data[15:0];
          end
          4'd9: begin
            sh_dport      <= in_data[31:16];
            sh_seq[31:16] <= in_data[15:0];
          end
          4'd10: begin
            sh_seq[15:0]  <= in_data[31:16];
            sh_ack[31:16] <= in_data[15:0];
          end
          4'd11: begin
            sh_ack[15:0] <= in_data[31:16];
            sh_data_off  <= in_data[15:12];
            sh_flags     <= in_data[7:0];
          end
          4'd12: sh_window <= in_data[31:16];
          default: ;
        endcase
      end
    end
  end

  // A new record may load in the same cycle the old one is taken, keeping
  // hdr_valid high across back-to-back records.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr_q     <= '0;
      hdr_valid <= 1'b0;
    end else if (load) begin
      hdr_q.mac_src     <= sh_src;
      hdr_q.ip_src      <= sh_ip_src;
      hdr_q.ip_dst      <= sh_ip_dst;
      hdr_q.src_port    <= sh_sport;
      hdr_q.dst_port    <= sh_dport;
      hdr_q.seq         <= sh_seq;
      hdr_q.ack         <= sh_ack;
      hdr_q.flags       <= sh_flags;
      hdr_q.window      <= sh_window;
      hdr_q.payload_len <= chk_payload_len;
      hdr_valid         <= 1'b1;
    end else if (hdr_ready) begin
      hdr_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (drop_inc && (drop_count != '1)) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end

  assign hdr_mac_src     = hdr_q.mac_src;
  assign hdr_ip_src      = hdr_q.ip_src;
  assign hdr_ip_dst      = hdr_q.ip_dst;
  assign hdr_src_port    = hdr_q.src_port;
  assign hdr_dst_port    = hdr_q.dst_port;
  assign hdr_seq         = hdr_q.seq;
  assign hdr_ack         = hdr_q.ack;
  assign hdr_flags       = hdr_q.flags;
  assign hdr_window      = hdr_q.window;
  assign hdr_payload_len = hdr_q.payload_len;

endmodule

// File: tb/tb_tcp_rx_parser.sv
// Directed bench for tcp_rx_parser: builds frames from field values,
// streams them word by word and checks the parsed records, backpressure,
// drop counting/saturation and reset behaviour against hand-computed values.
module tb_tcp_rx_parser;

  localparam logic [47:0] LOCAL_MAC = 48'h0200_0000_0001;

  logic        clk;
  logic        reset_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic        in_ready;
  logic [47:0] local_mac;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [47:0] hdr_mac_src;
  logic [31:0] hdr_ip_src;
  logic [31:0] hdr_ip_dst;
  logic [15:0] hdr_src_port;
  logic [15:0] hdr_dst_port;
  logic [31:0] hdr_seq;
  logic [31:0] hdr_ack;
  logic [7:0]  hdr_flags;
  logic [15:0] hdr_window;
  logic [15:0] hdr_payload_len;
  logic [15:0] drop_count;

  int assert_count = 0;
  int fail_count   = 0;

  // Field values used to build the next frame
  logic [47:0] f_dst, f_src;
  logic [15:0] f_eth, f_ip_len, f_sport, f_dport, f_win;
  logic [7:0]  f_ver_ihl, f_proto, f_off, f_flags;
  logic [31:0] f_ip_src, f_ip_dst, f_seq, f_ack;
  logic [31:0] frm [0:15];

  tcp_rx_parser #(.CNT_W(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_sop          (in_sop),
    .in_eop          (in_eop),
    .in_ready        (in_ready),
    .local_mac       (local_mac),
    .hdr_valid       (hdr_valid),
    .hdr_ready       (hdr_ready),
    .hdr_mac_src     (hdr_mac_src),
    .hdr_ip_src      (hdr_ip_src),
    .hdr_ip_dst      (hdr_ip_dst),
    .hdr_src_port    (hdr_src_port),
    .hdr_dst_port    (hdr_dst_port),
    .hdr_seq         (hdr_seq),
    .hdr_ack         (hdr_ack),
    .hdr_flags       (hdr_flags),
    .hdr_window      (hdr_window),
    .hdr_payload_len (hdr_payload_len),
    .drop_count      (drop_count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One immediate-assertion comparison with failure bookkeeping
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one word from a negedge, waits (bounded) for in_ready, lets the
  // next posedge take it and returns at the following negedge
  task automatic applyStimulus(input logic [31:0] d, input logic sop, input logic eop);
    int waited;
    waited   = 0;
    in_data  = d;
    in_sop   = sop;
    in_eop   = eop;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  // Baseline good frame: ip_len 60, offset 5 -> 20 payload bytes
  task automatic setDefaults();
    f_dst     = LOCAL_MAC;
    f_src     = 48'h0A0B_0C0D_0E0F;
    f_eth     = 16'h0800;
    f_ver_ihl = 8'h45;
    f_ip_len  = 16'd60;
    f_proto   = 8'd6;
    f_ip_src  = 32'hC0A8_0001;
    f_ip_dst  = 32'hC0A8_0002;
    f_sport   = 16'h1234;
    f_dport   = 16'h0050;
    f_seq     = 32'h1000_0001;
    f_ack     = 32'h2000_0002;
    f_off     = 8'h50;
    f_flags   = 8'h18;
    f_win     = 16'hFFFF;
  endtask

  task automatic buildFrame();
    frm[0]  = f_dst[47:16];
    frm[1]  = {f_dst[15:0], f_src[47:32]};
    frm[2]  = f_src[31:0];
    frm[3]  = {f_eth, f_ver_ihl, 8'h00};
    frm[4]  = {f_ip_len, 16'h0001};
    frm[5]  = {16'h4000, 8'd64, f_proto};
    frm[6]  = {16'h0000, f_ip_src[31:16]};
    frm[7]  = {f_ip_src[15:0], f_ip_dst[31:16]};
    frm[8]  = {f_ip_dst[15:0], f_sport};
    frm[9]  = {f_dport, f_seq[31:16]};
    frm[10] = {f_seq[15:0], f_ack[31:16]};
    frm[11] = {f_ack[15:0], f_off, f_flags};
    frm[12] = {f_win, 16'h0000};
    frm[13] = 32'h0000_DEAD;
    frm[14] = 32'hA5A5_5A5A;
    frm[15] = 32'h0102_0304;
  endtask

  // Sends words 0..last, with EOP on the last one when eop is set
  task automatic sendFrame(input int last, input logic eop);
    for (int i = 0; i <= last; i++)
      applyStimulus(frm[i], i == 0, (i == last) && eop);
  endtask

  task automatic consumeRecord();
    hdr_ready = 1'b1;
    @(negedge clk);
    hdr_ready = 1'b0;
  endtask

  // Directed sequence
  initial begin
    reset_n   = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    hdr_ready = 1'b0;
    local_mac = LOCAL_MAC;
    repeat (3) @(negedge clk);
    checkOutput("reset_hdr_valid", {63'd0, hdr_valid}, 64'd0);
    checkOutput("reset_drop_count", {48'd0, drop_count}, 64'd0);
    checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] good frame");
    setDefaults();
    buildFrame();
    for (int i = 0; i <= 12; i++) applyStimulus(frm[i], i == 0, 1'b0);
    checkOutput("good_valid_before_w13", {63'd0, hdr_valid}, 64'd0);
    applyStimulus(frm[13], 1'b0, 1'b0);
    checkOutput("good_valid_after_w13", {63'd0, hdr_valid}, 64'd1);
    checkOutput("good_mac_src", {16'd0, hdr_mac_src}, 64'h0A0B_0C0D_0E0F);
    checkOutput("good_ip_src", {32'd0, hdr_ip_src}, 64'hC0A8_0001);
    checkOutput("good_ip_dst", {32'd0, hdr_ip_dst}, 64'hC0A8_0002);
    checkOutput("good_sport", {48'd0, hdr_src_port}, 64'h1234);
    checkOutput("good_dport", {48'd0, hdr_dst_port}, 64'h0050);
    checkOutput("good_seq", {32'd0, hdr_seq}, 64'h1000_0001);
    checkOutput("good_ack", {32'd0, hdr_ack}, 64'h2000_0002);
    checkOutput("good_flags", {56'd0, hdr_flags}, 64'h18);
    checkOutput("good_window", {48'd0, hdr_window}, 64'hFFFF);
    checkOutput("good_payload_len", {48'd0, hdr_payload_len}, 64'd20);
    applyStimulus(frm[14], 1'b0, 1'b0);
    applyStimulus(frm[15], 1'b0, 1'b1);
    checkOutput("good_drop_count", {48'd0, drop_count}, 64'd0);
    consumeRecord();
    checkOutput("good_valid_cleared", {63'd0, hdr_valid}, 64'd0);

    $display("[TB] reject frames");
    setDefaults(); f_eth = 16'h86DD; buildFrame(); sendFrame(15, 1'b1);
    setDefaults(); f_proto = 8'd17; buildFrame(); sendFrame(15, 1'b1);
    setDefaults(); f_dst = 48'h0200_0000_0099; buildFrame(); sendFrame(15, 1'b1);
    checkOutput("reject_no_valid", {63'd0, hdr_valid}, 64'd0);
    checkOutput("reject_drop_count", {48'd0, drop_count}, 64'd3);

    $display("[TB] runt frame then broadcast good frame");
    setDefaults(); buildFrame(); sendFrame(7, 1'b1);
    checkOutput("runt_drop_count", {48'd0, drop_count}, 64'd4);
    checkOutput("runt_no_valid", {63'd0, hdr_valid}, 64'd0);
    setDefaults(); f_seq = 32'h3000_0003; f_dst = 48'hFFFF_FFFF_FFFF;
    buildFrame(); sendFrame(15, 1'b1);
    checkOutput("post_runt_valid", {63'd0, hdr_valid}, 64'd1);
    checkOutput("post_runt_seq", {32'd0, hdr_seq}, 64'h3000_0003);
    checkOutput("post_runt_payload", {48'd0, hdr_payload_len}, 64'd20);
    consumeRecord();

    $display("[TB] backpressure");
    setDefaults(); f_seq = 32'hAAAA_0001; buildFrame(); sendFrame(15, 1'b1);
    checkOutput("bp_first_valid", {63'd0, hdr_valid}, 64'd1);
    // second frame: ip_len 100, offset 8 -> 100 - 20 - 32 = 48 payload bytes
    setDefaults(); f_seq = 32'hBBBB_0002; f_ip_len = 16'd100; f_off = 8'h80;
    f_sport = 16'hBEEF; buildFrame();
    for (int i = 0; i <= 12; i++) applyStimulus(frm[i], i == 0, 1'b0);
    fork
      applyStimulus(frm[13], 1'b0, 1'b0);
      begin
        repeat (3) @(negedge clk);
        checkOutput("bp_in_ready_stalled", {63'd0, in_ready}, 64'd0);
        checkOutput("bp_first_seq_held", {32'd0, hdr_seq}, 64'hAAAA_0001);
        checkOutput("bp_first_valid_held", {63'd0, hdr_valid}, 64'd1);
        hdr_ready = 1'b1;
        @(negedge clk);
        hdr_ready = 1'b0;
      end
    join
    checkOutput("bp_second_valid", {63'd0, hdr_valid}, 64'd1);
    checkOutput("bp_second_seq", {32'd0, hdr_seq}, 64'hBBBB_0002);
    checkOutput("bp_second_sport", {48'd0, hdr_src_port}, 64'hBEEF);
    checkOutput("bp_second_payload", {48'd0, hdr_payload_len}, 64'd48);
    applyStimulus(frm[14], 1'b0, 1'b0);
    applyStimulus(frm[15], 1'b0, 1'b1);
    consumeRecord();

    $display("[TB] SOP inside header");
    setDefaults(); buildFrame(); sendFrame(4, 1'b0);
    setDefaults(); f_seq = 32'hCCCC_0003; buildFrame(); sendFrame(15, 1'b1);
    checkOutput("sop_mid_drop_count", {48'd0, drop_count}, 64'd5);
    checkOutput("sop_mid_valid", {63'd0, hdr_valid}, 64'd1);
    checkOutput("sop_mid_seq", {32'd0, hdr_seq}, 64'hCCCC_0003);
    consumeRecord();

    $display("[TB] drop counter saturation");
    // single-word SOP+EOP runts, one per cycle, 5 + 65530 = 65535
    in_data  = 32'h0;
    in_valid = 1'b1;
    in_sop   = 1'b1;
    in_eop   = 1'b1;
    repeat (65530) @(negedge clk);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    checkOutput("sat_reached", {48'd0, drop_count}, 64'hFFFF);
    setDefaults(); f_proto = 8'd17; buildFrame(); sendFrame(15, 1'b1);
    checkOutput("sat_held", {48'd0, drop_count}, 64'hFFFF);
    checkOutput("sat_no_valid", {63'd0, hdr_valid}, 64'd0);

    $display("[TB] reset mid-frame");
    setDefaults(); buildFrame(); sendFrame(8, 1'b0);
    in_data  = frm[9];
    in_valid = 1'b1;
    reset_n  = 1'b0;
    @(negedge clk);
    checkOutput("rst_hdr_valid", {63'd0, hdr_valid}, 64'd0);
    checkOutput("rst_drop_count", {48'd0, drop_count}, 64'd0);
    checkOutput("rst_seq", {32'd0, hdr_seq}, 64'd0);
    checkOutput("rst_ip_src", {32'd0, hdr_ip_src}, 64'd0);
    checkOutput("rst_mac_src", {16'd0, hdr_mac_src}, 64'd0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    @(negedge clk);
    setDefaults(); f_seq = 32'hDDDD_0004; buildFrame(); sendFrame(15, 1'b1);
    checkOutput("post_rst_valid", {63'd0, hdr_valid}, 64'd1);
    checkOutput("post_rst_seq", {32'd0, hdr_seq}, 64'hDDDD_0004);
    checkOutput("post_rst_payload", {48'd0, hdr_payload_len}, 64'd20);
    checkOutput("post_rst_drop_count", {48'd0, drop_count}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
